// File: rtl/multu_seq.sv
// rtl/multu_seq.sv - iterative shift-add multiplier retiring UNROLL multiplier bits per cycle
// Optional signed mode: define MULT_SIGNED_EN to add the is_signed port and magnitude/negate logic.
module multu_seq #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [CW-1:0]      count;
  logic               accept;
  logic               last;

`ifdef MULT_SIGNED_EN
  logic neg;
  logic neg_in;

  // Operand magnitudes and result sign; 2^(WIDTH-1) maps onto itself as an unsigned magnitude
  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    neg_in = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    result = neg ? (~acc_next + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_next;
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_next;
`endif

  // Partial product of the next UNROLL multiplier bits; mcand is pre-shifted to the current weight
  always_comb begin
    partial = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
    acc_next = acc + partial;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state, handshake outputs and datapath strobes
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == LAST) begin
          last       = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latch, shift-add iteration and result load on the final iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      high   <= '0;
      low    <= '0;
`ifdef MULT_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      count  <= '0;
`ifdef MULT_SIGNED_EN
      neg    <= neg_in;
`endif
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << UNROLL;
      mplier <= mplier >> UNROLL;
      count  <= count + CW'(1);
      if (last) begin
        high <= result[2*WIDTH-1:WIDTH];
        low  <= result[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// tb/tb_multu_seq.sv - scoreboard bench for multu_seq: lane 0 UNROLL=1, lane 1 UNROLL=4
module tb_multu_seq;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  typedef struct {
    int          lane;
    int          due;
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc;
  int          total;
  int          bad;
  exp_t        exp_q[$];
  logic [31:0] hold_h [2] = '{default: '0};
  logic [31:0] hold_l [2] = '{default: '0};
  int          last_due [2];

  logic        rst0, start0, busy0, done0;
  logic [31:0] a0, b0, high0, low0;
  logic        rst1, start1, busy1, done1;
  logic [31:0] a1, b1, high1, low1;
`ifdef MULT_SIGNED_EN
  logic        sg0, sg1;
`endif

  multu_seq #(.WIDTH(32), .UNROLL(1)) u_l0 (
    .clk(clk), .reset(rst0), .start(start0), .a(a0), .b(b0),
`ifdef MULT_SIGNED_EN
    .is_signed(sg0),
`endif
    .busy(busy0), .done(done0), .high(high0), .low(low0)
  );

  multu_seq #(.WIDTH(32), .UNROLL(4)) u_l1 (
    .clk(clk), .reset(rst1), .start(start1), .a(a1), .b(b1),
`ifdef MULT_SIGNED_EN
    .is_signed(sg1),
`endif
    .busy(busy1), .done(done1), .high(high1), .low(low1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    if (s && SIGNED_MODE) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic int front(input int k);
    for (int j = 0; j < exp_q.size(); j++) if (exp_q[j].lane == k) return j;
    return -1;
  endfunction

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL lane%0d %s cyc=%0d got=%h want=%h", k, nm, cyc, act, want);
    end
  endtask

  task automatic drive(input int k, input logic st, input logic [31:0] x, input logic [31:0] y);
    if (k == 0) begin start0 = st; a0 = x; b0 = y; end
    else        begin start1 = st; a1 = x; b1 = y; end
  endtask

  // Called on a negedge when the lane is expected to accept; expectation is queued immediately
  task automatic issue(input int k, input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] p;
    exp_t        e;
    p      = ref_prod(x, y, s);
    e.lane = k;
    e.due  = cyc + 1 + ((k == 0) ? 32 : 8);
    e.h    = p[63:32];
    e.l    = p[31:0];
    exp_q.push_back(e);
    last_due[k] = e.due;
    drive(k, 1'b1, x, y);
`ifdef MULT_SIGNED_EN
    if (k == 0) sg0 = s; else sg1 = s;
`endif
    @(negedge clk);
    drive(k, 1'b0, $urandom, $urandom);
  endtask

  task automatic wait_free(input int k);
    while (cyc < last_due[k]) @(negedge clk);
  endtask

  task automatic check_lane(input int k, input int n, input logic bz, input logic dn,
                            input logic [31:0] h, input logic [31:0] l);
    int   i;
    logic eb, ed;
    i  = front(k);
    eb = 1'b0;
    ed = 1'b0;
    if (i >= 0) begin
      ed = (exp_q[i].due == cyc);
      eb = (cyc >= exp_q[i].due - n) && (cyc < exp_q[i].due);
    end
    chk(k, "busy", {31'b0, bz}, {31'b0, eb});
    chk(k, "done", {31'b0, dn}, {31'b0, ed});
    if (ed) begin
      hold_h[k] = exp_q[i].h;
      hold_l[k] = exp_q[i].l;
      exp_q.delete(i);
    end
    chk(k, "high", h, hold_h[k]);
    chk(k, "low", l, hold_l[k]);
  endtask

  // Monitor: samples both lanes 2 time units after every rising edge
  initial forever begin
    @(posedge clk);
    #2;
    check_lane(0, 32, busy0, done0, high0, low0);
    check_lane(1, 8, busy1, done1, high1, low1);
  end

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
`ifdef MULT_SIGNED_EN
    sg0 = 1'b0;
    sg1 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk(0, "rst_busy_done", {30'b0, busy0, done0}, 32'h0);
    chk(0, "rst_high", high0, 32'h0);
    chk(0, "rst_low", low0, 32'h0);
    chk(1, "rst_busy_done", {30'b0, busy1, done1}, 32'h0);
    chk(1, "rst_high", high1, 32'h0);
    chk(1, "rst_low", low1, 32'h0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);

    // UNROLL=4: all-ones operands, then a back-to-back start in the DONE cycle
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_free(1);
    issue(1, 32'd7, 32'd6, 1'b0);

    // start pulsed mid-run must be ignored
    wait_free(1);
    repeat (2) @(negedge clk);
    issue(1, 32'h0001_2345, 32'h0006_789A, 1'b0);
    repeat (3) @(negedge clk);
    drive(1, 1'b1, 32'd9, 32'd9);
    @(negedge clk);
    drive(1, 1'b0, 32'd9, 32'd9);

`ifdef MULT_SIGNED_EN
    wait_free(1);
    issue(1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_free(1);
    issue(1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_free(1);
    issue(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
`endif

    // Randomized operands with random idle gaps (gap 0 gives back-to-back)
    for (int n = 0; n < 24; n++) begin
      wait_free(1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    end

    // UNROLL=1: basic product, then an abort by reset at iteration 10, then recovery
    wait_free(0);
    issue(0, 32'd3, 32'd5, 1'b0);
    wait_free(0);
    issue(0, $urandom, $urandom, 1'b0);
    repeat (9) @(negedge clk);
    rst0 = 1'b0;
    for (int j = exp_q.size() - 1; j >= 0; j--) if (exp_q[j].lane == 0) exp_q.delete(j);
    hold_h[0]   = '0;
    hold_l[0]   = '0;
    last_due[0] = cyc;
    #1;
    chk(0, "abort_busy_done", {30'b0, busy0, done0}, 32'h0);
    chk(0, "abort_high", high0, 32'h0);
    chk(0, "abort_low", low0, 32'h0);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      wait_free(0);
      issue(0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    end

    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multu_seq.md
Name: multu_seq

Overview:
- Parametrised iterative multiplier; next-generation successor to the single-cycle 32x32 multiply unit in the 54-instruction CPU datapath.
- Shift-add over several cycles, retiring UNROLL multiplier bits per cycle; trades latency for timing.
- Start/busy/done handshake to the EX-stage stall logic; writes a 2*WIDTH product split into high/low (HI/LO registers).

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.
- UNROLL, 1, multiplier bits retired per cycle; must divide WIDTH; 1, 2 and 4 are supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  multiplicand; latched on an accepted start.
- b  input  WIDTH  multiplier; latched on an accepted start.
- is_signed  input  1  present only with MULT_SIGNED_EN; latched on an accepted start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- high  output  WIDTH  upper half of the product.
- low  output  WIDTH  lower half of the product.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, high=0, low=0; internal accumulator and counter are cleared.
- N = WIDTH/UNROLL iterations.
- States are IDLE, RUN and DONE.
- IDLE -> RUN:
  - Trigger is start=1 at an edge.
  - Operands are latched (magnitudes when signed), the accumulator is cleared, count=0 and busy=1.
- RUN, each edge:
  - acc += (mcand * low UNROLL bits of mplier) << (count*UNROLL).
  - mplier >>= UNROLL; count++.
  - After the Nth iteration: go to DONE, busy=0, and load high/low from the acc.
- DONE:
  - done=1 for exactly one cycle; next state IDLE.
  - start=1 in DONE is accepted (state goes directly to RUN), so operations can run back to back.
- Latency: an accepted start at edge T gives done=1 in the cycle after edge T+N.
  - busy=1 during cycles T+1 .. T+N.
- start while busy=1 is ignored: no relatch, no queueing.
- a/b may change after acceptance with no effect on the result.
- high/low are held from one done until the next done. They do not change while busy.
- Arithmetic:
  - Product is exact, width 2*WIDTH, no truncation.
  - The accumulator is 2*WIDTH bits and cannot overflow.
- Reset asserted during RUN aborts the operation. All outputs return to 0; no done pulse.
- Operand zero still takes the full N iterations (no early termination).

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - The is_signed port exists.
  - If is_signed=1, the magnitudes |a| and |b| are multiplied. The product is two's-complement negated at the DONE load if sign(a) XOR sign(b).
  - The most-negative operand, magnitude 2^(WIDTH-1), is handled correctly.
  - Latency is unchanged.
- Undefined:
  - No is_signed port; the block is unsigned only.
  - No magnitude or negate logic is synthesised.

Test Plan (WIDTH=32):
- UNROLL=1, start with a=3, b=5 -> busy for 32 cycles; done 33 cycles after the start edge; high=0x00000000, low=0x0000000F.
- UNROLL=4, a=b=0xFFFFFFFF -> done 9 cycles after the start edge; high=0xFFFFFFFE, low=0x00000001.
- Back to back: second start (a=7, b=6) asserted in the DONE cycle of the first -> accepted with no idle cycle; next done gives low=0x0000002A; high/low hold the first result until then.
- start pulsed mid-RUN with a=9, b=9 -> ignored; original result delivered on time; busy never drops early.
- Reset driven low for 1 cycle at RUN iteration 10 -> immediately busy=0, done=0, high=low=0; no later done; a new start completes normally.
- MULT_SIGNED_EN, is_signed=1:
  - a=0xFFFFFFFE (-2), b=3 -> high=0xFFFFFFFF, low=0xFFFFFFFA.
  - a=b=0x80000000 -> high=0x40000000, low=0.
  - With is_signed=0, the same a=b=0x80000000 -> high=0x40000000, low=0.
